// File: rtl/conv_sa_out_collect_if.sv
// Post-row pair input and beat output stream bundle for conv_sa_out_collect.
// Lane count P defaults to the P macro (4 when undefined).
`ifndef P
`define P 4
`endif

interface conv_sa_out_collect_if #(
  parameter int P = `P
);
  logic            in_vld;
  logic [P*32-1:0] y1;
  logic [P*32-1:0] y2;
  logic            out_vld;
  logic            out_rdy;
  logic [P*32-1:0] out_data;
  logic            out_last;

  modport slave (
    input  in_vld, y1, y2, out_rdy,
    output out_vld, out_data, out_last
  );

  modport master (
    output in_vld, y1, y2, out_rdy,
    input  out_vld, out_data, out_last
  );
endinterface

// File: rtl/conv_sa_out_collect.sv
// Buffers {y1,y2} pairs from the post row and serialises them as two beats.
// Optional stall counter enabled by macro CONV_SA_OUT_STALL_CNT_EN.
`ifndef P
`define P 4
`endif

module conv_sa_out_collect #(
  parameter int P     = `P,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  conv_sa_out_collect_if.slave      io,
  output logic                      ovf,
  output logic [31:0]               stall_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SEND1 = 2'd1,
    SEND2 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [P*32-1:0] mem_y1 [DEPTH];
  logic [P*32-1:0] mem_y2 [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic xfer;
  logic pop;
  logic wr;
  logic drop;

  always_comb begin
    xfer = io.out_vld && io.out_rdy;
    pop  = xfer && (state == SEND2);
    // a full buffer still accepts when the head leaves this cycle
    wr   = io.in_vld && !clr && ((count != DEPTH_C) || pop);
    drop = io.in_vld && !clr && !wr;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (wr) state_nxt = SEND1;
      SEND1: if (xfer) state_nxt = SEND2;
      SEND2: begin
        if (xfer) begin
          if ((count != (AW+1)'(1)) || wr)
            state_nxt = SEND1;
          else
            state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (clr)
      state_nxt = EMPTY;
  end

  always_comb begin
    io.out_vld  = 1'b0;
    io.out_last = 1'b0;
    io.out_data = '0;
    unique case (state)
      SEND1: begin
        io.out_vld  = 1'b1;
        io.out_data = mem_y1[rd_ptr];
      end
      SEND2: begin
        io.out_vld  = 1'b1;
        io.out_last = 1'b1;
        io.out_data = mem_y2[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)
        ovf <= 1'b1;
    end
  end

  // payload storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (rstn && wr) begin
      mem_y1[wr_ptr] <= io.y1;
      mem_y2[wr_ptr] <= io.y2;
    end
  end

`ifdef CONV_SA_OUT_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (clr) begin
      stall_q <= '0;
    end else if (io.out_vld && !io.out_rdy && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/conv_sa_out_collect.md
CONV_SA_OUT_COLLECT -- requirements
Module: conv_sa_out_collect

Interface
REQ-001 The block SHALL have parameter P, default `P, giving the number of post-unit lanes per row.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of {y1,y2} pair entries buffered (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous flush of buffer and error flag.
REQ-006 The block SHALL have port in_vld, input, 1 bit: y1/y2 valid this cycle; the block has no backpressure toward the post row.
REQ-007 The block SHALL have port y1, input, P*32 bits: first output pixel vector from the post row.
REQ-008 The block SHALL have port y2, input, P*32 bits: second output pixel vector from the post row.
REQ-009 The block SHALL have port out_vld, output, 1 bit: out_data valid.
REQ-010 The block SHALL have port out_rdy, input, 1 bit: downstream ready.
REQ-011 The block SHALL have port out_data, output, P*32 bits: the current beat, y1 or y2 of the head entry.
REQ-012 The block SHALL have port out_last, output, 1 bit: the current beat is the y2 half.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, set when an input pair was dropped.
REQ-014 The block SHALL have port stall_cnt, output, 32 bits: backpressure counter (see Configuration).

Function
REQ-015 The block SHALL transfer a beat only on a cycle with out_vld=1 and out_rdy=1.
REQ-016 A cycle with in_vld=1 SHALL write {y1,y2} to the tail entry if count<DEPTH, or if count==DEPTH and the head entry pops in the same cycle.
REQ-017 A cycle with in_vld=1 that cannot write SHALL discard the pair, set ovf=1, and leave the buffer unchanged.
REQ-018 The block SHALL run an output FSM with states EMPTY, SEND1, SEND2.
REQ-019 In EMPTY, out_vld SHALL be 0.
REQ-020 The FSM SHALL go from EMPTY to SEND1 on the cycle after a write.
REQ-021 In SEND1, out_data SHALL equal the head y1 and out_last SHALL be 0.
REQ-022 On a transfer in SEND1, the FSM SHALL go to SEND2.
REQ-023 In SEND2, out_data SHALL equal the head y2 and out_last SHALL be 1.
REQ-024 On a transfer in SEND2, the block SHALL pop the head entry and go to SEND1 if entries remain (including one written in the same cycle), otherwise to EMPTY.
REQ-025 Latency from in_vld into an empty buffer to out_vld=1 with y1 on out_data SHALL be exactly 1 cycle.
REQ-026 With out_rdy held at 1, sustained throughput SHALL be one beat per cycle, so one pair every 2 cycles drains without loss.
REQ-027 While out_vld=1 and out_rdy=0, out_data and out_last SHALL hold stable.
REQ-028 Write and read pointers SHALL wrap modulo DEPTH.
REQ-029 count SHALL be DEPTH at most and never underflow.
REQ-030 clr=1 SHALL empty the buffer, force the FSM to EMPTY, and clear ovf and stall_cnt.
REQ-031 clr SHALL take priority over a simultaneous in_vld, which is ignored and does not set ovf.
REQ-032 The block SHALL pass data unmodified, with no arithmetic on y1/y2.

Reset
REQ-033 When rstn=0 at a clock edge, the block SHALL set out_vld=0, out_last=0, out_data=0, ovf=0, stall_cnt=0, count=0, both pointers=0, and the FSM to EMPTY.
REQ-034 Reset mid-transfer SHALL discard all buffered pairs, and no beat SHALL be emitted in the cycle after reset deasserts.
REQ-035 rstn SHALL take priority over clr and in_vld.

Configuration
REQ-036 With macro CONV_SA_OUT_STALL_CNT_EN defined, stall_cnt SHALL increment on every cycle with out_vld=1 and out_rdy=0, saturate at 0xFFFFFFFF, and be cleared by reset or clr.
REQ-037 Without CONV_SA_OUT_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; the port remains present.

Verification
REQ-038 Single pair: y1=lanes 0x11, y2=lanes 0x22, out_rdy=1 -> next cycle y1 with out_last=0, following cycle y2 with out_last=1, then out_vld=0.
REQ-039 Fill: out_rdy=0, 3 in_vld pulses with DEPTH=2 -> the first 2 pairs are held, ovf=1, and on draining only those 2 pairs appear, in order.
REQ-040 Full+pop: count=2, FSM in SEND2, out_rdy=1, in_vld=1 in the same cycle -> the pair is accepted, ovf stays 0, and count stays 2.
REQ-041 Stall: out_vld=1 and out_rdy=0 for 5 cycles -> out_data is stable, and stall_cnt=5 with the macro or 0 without it.
REQ-042 clr or rstn low while in SEND2 with 2 entries -> the next cycle shows out_vld=0, ovf=0, stall_cnt=0, and a later pair restarts at y1.
